// File: rtl/conv_feature_line_feeder_if.sv
// Bus between the feature-buffer read path, the line-feeder and the line cache.
// master drives configuration and the input stream; slave is the feeder itself.
interface conv_feature_line_feeder_if #(
  parameter int unsigned FEATURE_WIDTH = 8
);
  logic                       start;
  logic [9:0]                 row_size;
  logic [9:0]                 col_size;
  logic                       pad_en;
  logic                       hold;
  logic                       in_valid;
  logic                       in_ready;
  logic [2*FEATURE_WIDTH-1:0] in_data;
  logic                       wr_en;
  logic [2*FEATURE_WIDTH-1:0] wr_data;
  logic [9:0]                 shift_size;
  logic                       window_valid;
  logic                       busy;
  logic                       done;

  modport master (
    output start, row_size, col_size, pad_en, hold, in_valid, in_data,
    input  in_ready, wr_en, wr_data, shift_size, window_valid, busy, done
  );

  modport slave (
    input  start, row_size, col_size, pad_en, hold, in_valid, in_data,
    output in_ready, wr_en, wr_data, shift_size, window_valid, busy, done
  );
endinterface

// File: rtl/conv_feature_line_feeder.sv
// Feeds an unpadded feature stream into the convolution line cache, inserting an
// optional one-pixel zero border and flagging writes that complete a 3x3 window.
module conv_feature_line_feeder #(
  parameter int unsigned FEATURE_WIDTH = 8
) (
  input logic                      system_clk,
  input logic                      rst_n,
  conv_feature_line_feeder_if.slave bus
);

  localparam int unsigned DW = 2 * FEATURE_WIDTH;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e          state_q, state_d;
  logic [10:0]     r_q, r_d;
  logic [10:0]     c_q, c_d;
  logic [10:0]     w_q, w_d;
  logic [10:0]     h_q, h_d;
  logic            p_q, p_d;
  logic [9:0]      shift_q, shift_d;
  logic            wr_en_q, wr_en_d;
  logic            wv_q, wv_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;

  logic [10:0]     w_cfg, h_cfg, p_ext;
  logic            interior, last_pos, row_end, emit;

  always_comb begin
    w_cfg    = {1'b0, bus.row_size} + (bus.pad_en ? 11'd2 : 11'd0);
    h_cfg    = {1'b0, bus.col_size} + (bus.pad_en ? 11'd2 : 11'd0);
    p_ext    = {10'd0, p_q};
    interior = (c_q >= p_ext) && (c_q < (w_q - p_ext)) &&
               (r_q >= p_ext) && (r_q < (h_q - p_ext));
    row_end  = (c_q == (w_q - 11'd1));
    last_pos = row_end && (r_q == (h_q - 11'd1));
    // Border pixels are synthesised locally, so only interior ones wait on input.
    emit     = (state_q == StStream) && !bus.hold && (!interior || bus.in_valid);
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    w_d       = w_q;
    h_d       = h_q;
    p_d       = p_q;
    shift_d   = shift_q;
    wr_en_d   = emit;
    wv_d      = emit && (r_q >= 11'd2) && (c_q >= 11'd2);
    wr_data_d = wr_data_q;
    if (emit) begin
      wr_data_d = interior ? bus.in_data : '0;
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          w_d     = w_cfg;
          h_d     = h_cfg;
          p_d     = bus.pad_en;
          shift_d = w_cfg[9:0];
          r_d     = '0;
          c_d     = '0;
          if (bus.row_size == 10'd0 || bus.col_size == 10'd0 || w_cfg > 11'd1023) begin
            state_d = StDone;
          end else begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        if (emit) begin
          if (last_pos) begin
            state_d = StDone;
          end
          if (row_end) begin
            c_d = '0;
            r_d = r_q + 11'd1;
          end else begin
            c_d = c_q + 11'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      r_q       <= '0;
      c_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      p_q       <= 1'b0;
      shift_q   <= '0;
      wr_en_q   <= 1'b0;
      wv_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      w_q       <= w_d;
      h_q       <= h_d;
      p_q       <= p_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wv_q      <= wv_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready     = (state_q == StStream) && interior && !bus.hold;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.window_valid = wv_q;
  assign bus.shift_size   = shift_q;
  assign bus.busy         = (state_q == StStream);
  assign bus.done         = (state_q == StDone);

endmodule

// File: tb/tb_conv_feature_line_feeder.sv
// Scoreboard bench: frame tasks queue expected writes, a negedge monitor checks them.
module tb_conv_feature_line_feeder;

  localparam int unsigned FW = 8;
  localparam int unsigned DW = 2 * FW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          wv;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_feature_line_feeder_if #(.FEATURE_WIDTH(FW)) bus ();

  conv_feature_line_feeder #(.FEATURE_WIDTH(FW)) dut (
    .system_clk (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    total = 0;
  int    bad   = 0;
  int    nwr   = 0;
  string cur   = "init";

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur, name, got, want);
    end
  endtask

  // Monitor: every write is popped against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      nwr++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s/unexpected_write: got data %0d, expected no write", cur,
                 int'(bus.wr_data));
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_data", int'(bus.wr_data), int'(mon_e.data));
        check("window_valid", int'(bus.window_valid), int'(mon_e.wv));
        check("done_with_write", int'(bus.done), int'(mon_e.last));
      end
    end
  end

  task automatic check_zero(input string tag);
    cur = tag;
    check("wr_en", int'(bus.wr_en), 0);
    check("wr_data", int'(bus.wr_data), 0);
    check("window_valid", int'(bus.window_valid), 0);
    check("shift_size", int'(bus.shift_size), 0);
    check("busy", int'(bus.busy), 0);
    check("done", int'(bus.done), 0);
    check("in_ready", int'(bus.in_ready), 0);
  endtask

  task automatic push_frame(input int rs, input int cs, input int pad);
    int   w, h, k;
    exp_t e;
    w = rs + 2 * pad;
    h = cs + 2 * pad;
    k = 1;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (c >= pad && c < w - pad && r >= pad && r < h - pad) begin
          e.data = DW'(k);
          k++;
        end else begin
          e.data = '0;
        end
        e.wv   = (r >= 2 && c >= 2);
        e.last = (r == h - 1 && c == w - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input string label, input int rs, input int cs, input int pad,
                           input int hold_at, input int hold_len, input int bubble,
                           input int restart_at, input int reset_at,
                           input int exp_done_cyc, input int exp_writes, input int exp_rdy,
                           input int exp_shift);
    int word, rdy, done_cyc, w0;
    bit did_reset;
    cur       = label;
    word      = 1;
    rdy       = 0;
    done_cyc  = -1;
    did_reset = 1'b0;
    w0        = nwr;
    if (rs != 0 && cs != 0 && rs + 2 * pad <= 1023) push_frame(rs, cs, pad);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      bus.start    = (cyc == 0 || cyc == restart_at);
      bus.row_size = 10'(rs);
      bus.col_size = 10'(cs);
      bus.pad_en   = (pad != 0);
      bus.hold     = (cyc >= hold_at && cyc < hold_at + hold_len);
      bus.in_valid = (bubble != 0) ? (cyc % 2 == 1) : 1'b1;
      bus.in_data  = DW'(word);
      #1;
      if (bus.in_ready) rdy++;
      if (bus.in_ready && bus.in_valid) word++;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_zero({label, "_rst"});
        exp_q.delete();
        did_reset = 1'b1;
        break;
      end
    end
    bus.start    = 1'b0;
    bus.hold     = 1'b0;
    bus.in_valid = 1'b0;
    if (did_reset) begin
      check("writes_before_reset", nwr - w0, exp_writes);
      #2;
      rst_n = 1'b1;
      return;
    end
    if (done_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL %s/done_timeout: got no done, expected done within 300 cycles", label);
    end
    if (exp_done_cyc >= 0) check("done_cycle", done_cyc, exp_done_cyc);
    check("writes", nwr - w0, exp_writes);
    if (exp_rdy >= 0) check("in_ready_cycles", rdy, exp_rdy);
    if (exp_shift >= 0) check("shift_size", int'(bus.shift_size), exp_shift);
    repeat (3) @(negedge clk);
    #1;
    check("busy_after", int'(bus.busy), 0);
    check("done_after", int'(bus.done), 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.row_size = '0;
    bus.col_size = '0;
    bus.pad_en   = 1'b0;
    bus.hold     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // label rs cs pad hold_at hold_len bubble restart reset done_cyc writes rdy shift
    run_frame("padded",   4, 3, 1, -10, 0, 0, 15, -1, 31, 30, 12, 6);
    run_frame("unpadded", 3, 3, 0, -10, 0, 0,  9, -1, 10,  9,  9, 3);
    run_frame("hold",     4, 3, 1,  10, 5, 0, -1, -1, 36, 30, 12, 6);
    run_frame("bubble",   4, 3, 1, -10, 0, 1, -1, -1, 43, 30, 24, 6);
    run_frame("zero_col", 4, 0, 1, -10, 0, 0, -1, -1,  1,  0,  0, 6);
    run_frame("too_wide", 1023, 2, 1, -10, 0, 0, -1, -1, 1, 0,  0, -1);
    run_frame("midreset", 4, 3, 1, -10, 0, 0, -1, 11, -1, 10, -1, -1);
    run_frame("after_rst", 4, 3, 1, -10, 0, 0, -1, -1, 31, 30, 12, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_feature_line_feeder.md
Name: conv_feature_line_feeder

Overview:
- Writer-side feeder for the RAM-based convolution line cache.
- Accepts an unpadded feature map as a valid/ready stream, inserts zero padding around the map, and drives one write per padded pixel into the line cache (wr_en/wr_data).
- Supplies the matching shift_size and flags each write that completes a full 3x3 window.
- Sits between the feature-buffer read path and the line cache that feeds the convolution array.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH: width of one feature; data words are FEATURE_WIDTH*2 bits.

Ports:
- system_clk  in  1  clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches configuration and begins a frame.
- row_size  in  10  unpadded pixels per row.
- col_size  in  10  unpadded rows.
- pad_en  in  1  1 adds a one-pixel zero border; 0 adds no border.
- hold  in  1  downstream backpressure; freezes emission.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  FEATURE_WIDTH*2  input feature pair.
- wr_en  out  1  line-cache write strobe.
- wr_data  out  FEATURE_WIDTH*2  line-cache write data.
- shift_size  out  10  padded row width W, held constant for the whole frame.
- window_valid  out  1  qualifies wr_en; this write completes a 3x3 window.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no resume.
- Frame geometry:
  - P = pad_en.
  - Padded width W = row_size + 2P; padded height H = col_size + 2P.
  - Configuration is latched at start.
  - shift_size = latched W, registered; it updates the cycle after start and holds after done.
- Counters:
  - Column counter c runs 0..W-1 and row counter r runs 0..H-1.
  - c advances on each emission and wraps to 0 at W-1, at which point r increments.
- Interior and border:
  - A position is interior when P ≤ c < W-P and P ≤ r < H-P; otherwise it is border.
- FSM states:
  - IDLE: busy=0. On start, goes to STREAM, clearing r and c. If row_size==0, col_size==0, or W>1023, it goes to DONE instead and issues no writes.
  - STREAM: busy=1.
    - Emission conditions: a border position emits when hold==0; an interior position emits when hold==0 and in_valid==1.
    - in_ready is combinational: (state==STREAM) & interior & ~hold.
    - Border positions never assert in_ready.
    - When position (H-1, W-1) emits, the state goes to DONE.
  - DONE: lasts one cycle; done=1, busy=0; then returns to IDLE.
- Output timing:
  - wr_en, wr_data and window_valid are registered, so an emission decided in cycle n appears in cycle n+1.
  - wr_data is in_data for interior positions and zero for border positions.
  - The last wr_en is coincident with done.
  - window_valid is 1 with wr_en exactly when r≥2 and c≥2 at the emitted position.
  - wr_data holds its last value when wr_en=0.
- Stalls:
  - hold=1 in STREAM leaves counters unchanged and forces wr_en=0 next cycle.
  - An input bubble (in_valid=0) at an interior position behaves the same way.
  - Border emission does not wait on in_valid.
- Boundary and concurrency rules:
  - start while busy or in DONE is ignored.
  - A start in the same cycle as the final emission is ignored.
  - Input words offered while in_ready=0 are not consumed.

Test Plan:
- Padded frame: row_size=4, col_size=3, pad_en=1, in_valid=1, hold=0, inputs 1..12.
  - Exactly 30 wr_en cycles, contiguous; shift_size=6.
  - First 7 writes are 0, the 8th write is 1, the last 7 writes are 0.
  - in_ready high for exactly 12 cycles; window_valid high on 12 writes; done coincident with the 30th write.
- Unpadded frame: row_size=3, col_size=3, pad_en=0.
  - 9 writes equal to the inputs; shift_size=3; window_valid only on the 9th write.
- Backpressure: same as scenario 1 with hold=1 for 5 cycles mid-frame.
  - wr_en gap of 5 cycles; sequence identical; still 30 writes.
- Input bubbles: same as scenario 1 with in_valid low every other cycle.
  - Border writes continue unstalled; interior writes stall; data order 1..12 preserved.
- Degenerate size and restart: start with col_size=0.
  - done pulses the cycle after start, wr_en never asserts.
  - A second start during a busy frame has no effect on the writes.
- Mid-frame reset: assert rst_n=0 after 10 writes.
  - All outputs 0, FSM in IDLE.
  - A fresh start yields a full correct 30-write frame.
